sync_filter_multi: RTL and testbench

- Multi-channel single-bit synchroniser for asynchronous inputs (buttons, external status pins, cross-domain flags) entering the clock_dst domain.
- Each channel has a parametrised-depth sync chain, a stability (glitch) filter, and registered rise/fall event pulses.
- Successor to the plain unfiltered sync chain: adds reset, channel count, filtering, edge events and optional sticky flags.

---
 rtl/sync_pkg.sv | 18 +
 rtl/sync_filter_channel.sv | 108 ++++++++++
 rtl/sync_filter_multi.sv | 46 ++++
 tb/tb_sync_filter_multi.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared helpers for the filtered multi-channel synchroniser: width arithmetic
// and the elaboration-time parameter legality check.
package sync_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    function automatic bit params_ok(input int sync_stage, input int filter_len);
        return (sync_stage >= 32'sd2) && (filter_len >= 32'sd1);
    endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// One synchroniser channel: sync chain, stability filter, edge pulses.
// Sticky event flag is present only when SYNC_STICKY_EN is defined.
module sync_filter_channel
    import sync_pkg::*;
#(
    parameter int   SYNC_STAGE = 2,
    parameter int   FILTER_LEN = 4,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clock_dst,
    input  logic reset_dst,
    input  logic src,
    output logic dst,
    output logic rise,
`ifdef SYNC_STICKY_EN
    input  logic sticky_clr,
    output logic sticky,
`endif
    output logic fall
);

    localparam int CNT_W = clog2(FILTER_LEN) + 1;

    if (!params_ok(SYNC_STAGE, FILTER_LEN)) begin : g_bad_params
        $error("sync_filter_channel: SYNC_STAGE must be >= 2 and FILTER_LEN >= 1");
    end

    logic [SYNC_STAGE-1:0] chain_q, chain_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  dst_q, dst_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  s_s;

    assign s_s = chain_q[SYNC_STAGE-1];

    // Plain shift chain; nothing may sit between the stages.
    always_comb begin
        chain_d = {chain_q[SYNC_STAGE-2:0], src};
    end

    // Stability filter: accept s only after it has differed from dst for FILTER_LEN evaluations.
    always_comb begin
        cnt_d  = '0;
        dst_d  = dst_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s_s == dst_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            cnt_d  = '0;
            dst_d  = s_s;
            rise_d = s_s;
            fall_d = ~s_s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset overrides any in-flight filter count.
    always_ff @(posedge clock_dst) begin
        if (reset_dst) begin
            chain_q <= {SYNC_STAGE{RESET_VAL}};
            cnt_q   <= '0;
            dst_q   <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dst  = dst_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef SYNC_STICKY_EN
    logic sticky_q, sticky_d;

    // Event-seen flag; a new event beats a clear in the same cycle.
    always_comb begin
        sticky_d = sticky_q;
        if (rise_q || fall_q) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clock_dst) begin
        if (reset_dst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`endif

endmodule

// File: rtl/sync_filter_multi.sv
// Multi-channel filtered synchroniser into clock_dst; independent channels.
// Define SYNC_STICKY_EN to add per-channel sticky event flags and clears.
module sync_filter_multi
    import sync_pkg::*;
#(
    parameter int                  CHANNELS   = 4,
    parameter int                  SYNC_STAGE = 2,
    parameter int                  FILTER_LEN = 4,
    parameter logic [CHANNELS-1:0] RESET_VAL  = {CHANNELS{1'b0}}
) (
    input  logic                clock_dst,
    input  logic                reset_dst,
    input  logic [CHANNELS-1:0] src,
    output logic [CHANNELS-1:0] dst,
    output logic [CHANNELS-1:0] rise,
`ifdef SYNC_STICKY_EN
    input  logic [CHANNELS-1:0] sticky_clr,
    output logic [CHANNELS-1:0] sticky,
`endif
    output logic [CHANNELS-1:0] fall
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("sync_filter_multi: CHANNELS must be >= 1");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        sync_filter_channel #(
            .SYNC_STAGE (SYNC_STAGE),
            .FILTER_LEN (FILTER_LEN),
            .RESET_VAL  (RESET_VAL[g])
        ) u_ch (
            .clock_dst  (clock_dst),
            .reset_dst  (reset_dst),
            .src        (src[g]),
            .dst        (dst[g]),
            .rise       (rise[g]),
`ifdef SYNC_STICKY_EN
            .sticky_clr (sticky_clr[g]),
            .sticky     (sticky[g]),
`endif
            .fall       (fall[g])
        );
    end

endmodule

// File: tb/tb_sync_filter_multi.sv
// Directed plus randomized bench for sync_filter_multi, run on two parameter sets
// against a window-based reference model.
module tb_sync_filter_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] src = 4'b0000;
    logic [3:0] clr = 4'b0000;
    logic [3:0] dst_a, rise_a, fall_a, dst_b, rise_b, fall_b;
    logic [3:0] sticky_a, sticky_b;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    sync_filter_multi #(.CHANNELS(4), .SYNC_STAGE(2), .FILTER_LEN(4), .RESET_VAL(4'b1000)) u_dut_a (
        .clock_dst (clk),
        .reset_dst (rst),
        .src       (src),
        .dst       (dst_a),
        .rise      (rise_a),
`ifdef SYNC_STICKY_EN
        .sticky_clr(clr),
        .sticky    (sticky_a),
`endif
        .fall      (fall_a)
    );

    sync_filter_multi #(.CHANNELS(4), .SYNC_STAGE(3), .FILTER_LEN(1), .RESET_VAL(4'b0000)) u_dut_b (
        .clock_dst (clk),
        .reset_dst (rst),
        .src       (src),
        .dst       (dst_b),
        .rise      (rise_b),
`ifdef SYNC_STICKY_EN
        .sticky_clr(clr),
        .sticky    (sticky_b),
`endif
        .fall      (fall_b)
    );

`ifndef SYNC_STICKY_EN
    assign sticky_a = 4'b0000;
    assign sticky_b = 4'b0000;
`endif

    // Reference model: s at an edge is src seen SYNC_STAGE edges earlier; a channel
    // accepts when the last FILTER_LEN s values all differ from its current dst.
    int         ss_m [2] = '{2, 3};
    int         fl_m [2] = '{4, 1};
    logic [3:0] rv_m [2] = '{4'b1000, 4'b0000};
    logic [3:0] pipe_m [2][8];
    logic [3:0] win_m  [2][8];
    int         wcnt_m [2];
    logic [3:0] dst_m [2], rise_m [2], fall_m [2], sticky_m [2];

    task automatic model_edge(input int k, input logic r, input logic [3:0] s_in, input logic [3:0] c);
        logic [3:0] s_ev;
        logic [3:0] acc;
        logic       all_diff;
        if (r) begin
            for (int j = 0; j < 8; j++) pipe_m[k][j] = rv_m[k];
            dst_m[k]    = rv_m[k];
            rise_m[k]   = 4'b0000;
            fall_m[k]   = 4'b0000;
            sticky_m[k] = 4'b0000;
            wcnt_m[k]   = 0;
        end else begin
            sticky_m[k] = rise_m[k] | fall_m[k] | (sticky_m[k] & ~c);
            s_ev = pipe_m[k][ss_m[k]-1];
            for (int j = 7; j > 0; j--) pipe_m[k][j] = pipe_m[k][j-1];
            pipe_m[k][0] = s_in;
            for (int j = 7; j > 0; j--) win_m[k][j] = win_m[k][j-1];
            win_m[k][0] = s_ev;
            if (wcnt_m[k] < 8) wcnt_m[k]++;
            acc = 4'b0000;
            for (int ch = 0; ch < 4; ch++) begin
                all_diff = (wcnt_m[k] >= fl_m[k]);
                for (int j = 0; j < fl_m[k]; j++)
                    if (win_m[k][j][ch] == dst_m[k][ch]) all_diff = 1'b0;
                acc[ch] = all_diff;
            end
            rise_m[k] = acc & s_ev;
            fall_m[k] = acc & ~s_ev;
            dst_m[k]  = (dst_m[k] & ~acc) | (s_ev & acc);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic r, input logic [3:0] c);
        src = s;
        rst = r;
        clr = c;
        @(posedge clk);
        model_edge(0, r, s, c);
        model_edge(1, r, s, c);
        #1;
        chk("dst_a",  dst_a,  dst_m[0]);
        chk("rise_a", rise_a, rise_m[0]);
        chk("fall_a", fall_a, fall_m[0]);
        chk("dst_b",  dst_b,  dst_m[1]);
        chk("rise_b", rise_b, rise_m[1]);
        chk("fall_b", fall_b, fall_m[1]);
        chk("excl_a", rise_a & fall_a, 4'b0000);
`ifdef SYNC_STICKY_EN
        chk("sticky_a", sticky_a, sticky_m[0]);
        chk("sticky_b", sticky_b, sticky_m[1]);
`endif
    endtask

    initial begin
        logic [3:0] rs;
        // Reset state
        repeat (3) step(4'b0000, 1'b1, 4'b0000);
        chk("rst_dst_a", dst_a, 4'b1000);
        chk("rst_dst_b", dst_b, 4'b0000);
        chk("rst_rise_a", rise_a | fall_a, 4'b0000);

        // Channel 0 rises after release; channel 3 falls from its reset value of 1
        repeat (3) step(4'b0001, 1'b0, 4'b0000);
        step(4'b0001, 1'b0, 4'b0000);
        chk("lat_rise_b", rise_b, 4'b0001);
        step(4'b0001, 1'b0, 4'b0000);
        chk("pre_rise_a", rise_a, 4'b0000);
        step(4'b0001, 1'b0, 4'b0000);
        chk("lat_rise_a", rise_a, 4'b0001);
        chk("lat_fall_a", fall_a, 4'b1000);
        chk("lat_dst_a",  dst_a,  4'b0001);
        step(4'b0001, 1'b0, 4'b0000);
        chk("one_cycle_a", rise_a, 4'b0000);

        // Three-cycle glitch on channel 1 is discarded by A, followed by B
        repeat (3) step(4'b0011, 1'b0, 4'b0000);
        repeat (8) step(4'b0001, 1'b0, 4'b0000);
        chk("glitch_dst_a", dst_a, 4'b0001);
        // Four-cycle pulse is accepted, then falls
        repeat (4) step(4'b0011, 1'b0, 4'b0000);
        repeat (2) step(4'b0001, 1'b0, 4'b0000);
        chk("pulse_dst_a", dst_a, 4'b0011);
        repeat (8) step(4'b0001, 1'b0, 4'b0000);
        chk("pulse_back_a", dst_a, 4'b0001);

        // Reset mid-filter on channel 3, then fall[3] from its reset value
        repeat (2) step(4'b1001, 1'b0, 4'b0000);
        step(4'b1001, 1'b1, 4'b0000);
        chk("midrst_dst_a", dst_a, 4'b1000);
        chk("midrst_evt_a", rise_a | fall_a, 4'b0000);
        repeat (5) step(4'b0001, 1'b0, 4'b0000);
        step(4'b0001, 1'b0, 4'b0000);
        chk("rel_fall_a", fall_a, 4'b1000);

        // All channels switch together
        repeat (8) step(4'b0000, 1'b0, 4'b0000);
        repeat (5) step(4'b1111, 1'b0, 4'b0000);
        step(4'b1111, 1'b0, 4'b0000);
        chk("all_rise_a", rise_a, 4'b1111);
        chk("all_dst_a",  dst_a,  4'b1111);
`ifdef SYNC_STICKY_EN
        step(4'b1111, 1'b0, 4'b0000);
        chk("sticky_set_a", sticky_a, 4'b1111);
        step(4'b1111, 1'b0, 4'b1111);
        chk("sticky_clr_a", sticky_a, 4'b0000);
        // Clear applied in the cycle a fall is presented: set wins
        repeat (5) step(4'b0000, 1'b0, 4'b0000);
        step(4'b0000, 1'b0, 4'b0000);
        chk("fall_evt_a", fall_a, 4'b1111);
        step(4'b0000, 1'b0, 4'b1111);
        chk("sticky_win_a", sticky_a, 4'b1111);
`endif

        // Randomized phase
        rs = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(5, 0) == 0) rs[ch] = ~rs[ch];
            step(rs, ($urandom_range(99, 0) == 0), 4'($urandom_range(15, 0)) & 4'($urandom_range(15, 0)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
